// File: rtl/axi_common_types_pkg.sv
// Shared AXI types for the burst engine and its helpers.
//   axi_resp_e  : AXI response codes
//   axi_burst_e : AXI burst types
//   eng_state_e : burst-engine FSM states
//   resp_worst(): merges two responses, keeping the more severe one
package axi_common_types_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RADDR = 3'd4,
        RDATA = 3'd5
    } eng_state_e;

    // Severity order is DECERR > SLVERR > EXOKAY > OKAY.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        if (a == DECERR || b == DECERR) return DECERR;
        if (a == SLVERR || b == SLVERR) return SLVERR;
        if (a == EXOKAY || b == EXOKAY) return EXOKAY;
        return OKAY;
    endfunction

endpackage

// File: rtl/axi_hs_watchdog.sv
// Handshake watchdog for the burst engine.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   active        : engine is busy with a transaction
//   hs            : any channel handshake this cycle
//   clr           : clears the sticky expire flag (has priority)
//   expire        : sticky; set after TIMEOUT_CYC busy cycles without a handshake
module axi_hs_watchdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic active,
    input  logic hs,
    input  logic clr,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;
    logic          r_expire;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else begin
            // Counter saturates so a long stall cannot wrap back to zero.
            if (!active || hs)
                r_cnt <= '0;
            else if (r_cnt != CW'(TIMEOUT_CYC))
                r_cnt <= r_cnt + CW'(1);

            if (clr)
                r_expire <= 1'b0;
            else if (active && !hs && r_cnt == CW'(TIMEOUT_CYC - 1))
                r_expire <= 1'b1;
        end
    end

    assign expire = r_expire;

endmodule

// File: rtl/axi_master_burst_engine.sv
// Single-outstanding AXI4 initiator. Takes one command, runs AW->W->B or
// AR->R, then pulses done with the merged response.
//   ACLK/ARESETn        : clock, asynchronous active-low reset
//   cmd_*               : command handshake and fields (LEN/SIZE/BURST unchanged)
//   wd_*                : write-data stream in (passed through to W)
//   rd_*                : read-data stream out (passed through from R)
//   done_valid/resp/err : one-cycle completion pulse, worst-of response, protocol error
//   timeout             : sticky handshake watchdog flag, cleared on next command
//   M_AW*/M_W*/M_B*/M_AR*/M_R* : AXI4 master port; side-band fields tied to zero
module axi_master_burst_engine
    import axi_common_types_pkg::*;
#(
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done_valid,
    output logic [1:0]          done_resp,
    output logic                done_err,
    output logic                timeout,
    output logic [ID_W-1:0]     M_AWID,
    output logic [ADDR_W-1:0]   M_AWADDR,
    output logic [7:0]          M_AWLEN,
    output logic [2:0]          M_AWSIZE,
    output logic [1:0]          M_AWBURST,
    output logic                M_AWLOCK,
    output logic [3:0]          M_AWCACHE,
    output logic [2:0]          M_AWPROT,
    output logic [3:0]          M_AWQOS,
    output logic [3:0]          M_AWREGION,
    output logic                M_AWUSER,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    output logic                M_WLAST,
    output logic                M_WUSER,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    input  logic [ID_W-1:0]     M_BID,
    input  logic [1:0]          M_BRESP,
    input  logic                M_BVALID,
    output logic                M_BREADY,
    output logic [ID_W-1:0]     M_ARID,
    output logic [ADDR_W-1:0]   M_ARADDR,
    output logic [7:0]          M_ARLEN,
    output logic [2:0]          M_ARSIZE,
    output logic [1:0]          M_ARBURST,
    output logic                M_ARLOCK,
    output logic [3:0]          M_ARCACHE,
    output logic [2:0]          M_ARPROT,
    output logic [3:0]          M_ARQOS,
    output logic [3:0]          M_ARREGION,
    output logic                M_ARUSER,
    output logic                M_ARVALID,
    input  logic                M_ARREADY,
    input  logic [ID_W-1:0]     M_RID,
    input  logic [DATA_W-1:0]   M_RDATA,
    input  logic [1:0]          M_RRESP,
    input  logic                M_RLAST,
    input  logic                M_RVALID,
    output logic                M_RREADY
);
    eng_state_e        r_state, w_state_next;
    logic              r_cmd_ready;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    axi_burst_e        r_burst;
    logic [3:0]        r_cnt;
    logic [1:0]        r_resp_acc;
    logic              r_err_acc;
    logic              r_done_valid;
    logic [1:0]        r_done_resp;
    logic              r_done_err;

    logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_any_hs, w_r_beat_err;

    // Channel VALID/READY are decoded from the registered state, so they
    // drop asynchronously with reset and cannot glitch on command inputs.
    assign M_AWVALID = (r_state == WADDR);
    assign M_ARVALID = (r_state == RADDR);
    assign M_WVALID  = (r_state == WDATA) && wd_valid;
    assign wd_ready  = (r_state == WDATA) && M_WREADY;
    assign M_BREADY  = (r_state == WRESP);
    assign M_RREADY  = (r_state == RDATA) && rd_ready;
    assign rd_valid  = (r_state == RDATA) && M_RVALID;

    assign w_cmd_hs = cmd_valid && r_cmd_ready;
    assign w_aw_hs  = M_AWVALID && M_AWREADY;
    assign w_w_hs   = M_WVALID && M_WREADY;
    assign w_b_hs   = M_BREADY && M_BVALID;
    assign w_ar_hs  = M_ARVALID && M_ARREADY;
    assign w_r_hs   = M_RREADY && M_RVALID;
    assign w_any_hs = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;

    // A read beat is bad if its ID is foreign or RLAST disagrees with the
    // beat position (early RLAST, or missing RLAST on the final beat).
    assign w_r_beat_err = (M_RID != r_id) || (M_RLAST != (r_cnt == r_len));

    assign M_AWID     = r_id;
    assign M_AWADDR   = r_addr;
    assign M_AWLEN    = {4'b0, r_len};
    assign M_AWSIZE   = r_size;
    assign M_AWBURST  = r_burst;
    assign M_AWLOCK   = 1'b0;
    assign M_AWCACHE  = 4'b0;
    assign M_AWPROT   = 3'b0;
    assign M_AWQOS    = 4'b0;
    assign M_AWREGION = 4'b0;
    assign M_AWUSER   = 1'b0;
    assign M_ARID     = r_id;
    assign M_ARADDR   = r_addr;
    assign M_ARLEN    = {4'b0, r_len};
    assign M_ARSIZE   = r_size;
    assign M_ARBURST  = r_burst;
    assign M_ARLOCK   = 1'b0;
    assign M_ARCACHE  = 4'b0;
    assign M_ARPROT   = 3'b0;
    assign M_ARQOS    = 4'b0;
    assign M_ARREGION = 4'b0;
    assign M_ARUSER   = 1'b0;

    assign M_WDATA = wd_data;
    assign M_WSTRB = wd_strb;
    assign M_WLAST = (r_cnt == r_len);
    assign M_WUSER = 1'b0;
    assign rd_data = M_RDATA;
    assign rd_last = M_RLAST;

    assign cmd_ready  = r_cmd_ready;
    assign done_valid = r_done_valid;
    assign done_resp  = r_done_resp;
    assign done_err   = r_done_err;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cmd_hs) w_state_next = cmd_write ? WADDR : RADDR;
            WADDR:   if (w_aw_hs) w_state_next = WDATA;
            WDATA:   if (w_w_hs && M_WLAST) w_state_next = WRESP;
            WRESP:   if (w_b_hs) w_state_next = IDLE;
            RADDR:   if (w_ar_hs) w_state_next = RDATA;
            RDATA:   if (w_r_hs && M_RLAST) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b0;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= FIXED;
            r_cnt        <= '0;
            r_resp_acc   <= OKAY;
            r_err_acc    <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_resp  <= OKAY;
            r_done_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cmd_ready  <= (w_state_next == IDLE);
            r_done_valid <= 1'b0;

            if (w_cmd_hs) begin
                r_id       <= cmd_id;
                r_addr     <= cmd_addr;
                r_len      <= cmd_len;
                r_size     <= cmd_size;
                r_burst    <= axi_burst_e'(cmd_burst);
                r_resp_acc <= OKAY;
                r_err_acc  <= 1'b0;
            end

            if (w_aw_hs || w_ar_hs)
                r_cnt <= '0;
            else if (w_w_hs || w_r_hs)
                r_cnt <= r_cnt + 4'd1;

            if (w_b_hs) begin
                r_done_valid <= 1'b1;
                r_done_resp  <= M_BRESP;
                r_done_err   <= (M_BID != r_id);
            end

            if (w_r_hs) begin
                r_resp_acc <= resp_worst(r_resp_acc, M_RRESP);
                r_err_acc  <= r_err_acc || w_r_beat_err;
                if (M_RLAST) begin
                    r_done_valid <= 1'b1;
                    r_done_resp  <= resp_worst(r_resp_acc, M_RRESP);
                    r_done_err   <= r_err_acc || w_r_beat_err;
                end
            end
        end
    end

    axi_hs_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .active  (r_state != IDLE),
        .hs      (w_any_hs),
        .clr     (w_cmd_hs),
        .expire  (timeout)
    );

endmodule

// File: tb/tb_axi_master_burst_engine.sv
// Directed + randomized bench for axi_master_burst_engine. The bench acts as
// both the command user and the AXI slave; expectations come from a simple
// per-transaction model (beat order, worst-of response, error rules).
module tb_axi_master_burst_engine;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done_valid, done_err, timeout;
    logic [1:0]  done_resp;
    logic [3:0]  M_AWID, M_ARID, M_BID, M_RID;
    logic [31:0] M_AWADDR, M_ARADDR, M_WDATA, M_RDATA;
    logic [7:0]  M_AWLEN, M_ARLEN;
    logic [2:0]  M_AWSIZE, M_ARSIZE, M_AWPROT, M_ARPROT;
    logic [1:0]  M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
    logic        M_AWLOCK, M_ARLOCK, M_AWUSER, M_ARUSER, M_WUSER;
    logic [3:0]  M_AWCACHE, M_ARCACHE, M_AWQOS, M_ARQOS, M_AWREGION, M_ARREGION;
    logic        M_AWVALID, M_AWREADY, M_ARVALID, M_ARREADY;
    logic [3:0]  M_WSTRB;
    logic        M_WLAST, M_WVALID, M_WREADY;
    logic        M_BVALID, M_BREADY;
    logic        M_RLAST, M_RVALID, M_RREADY;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    axi_master_burst_engine #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(256)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err), .timeout(timeout),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK), .M_AWCACHE(M_AWCACHE), .M_AWPROT(M_AWPROT),
        .M_AWQOS(M_AWQOS), .M_AWREGION(M_AWREGION), .M_AWUSER(M_AWUSER),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WUSER(M_WUSER),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK), .M_ARCACHE(M_ARCACHE), .M_ARPROT(M_ARPROT),
        .M_ARQOS(M_ARQOS), .M_ARREGION(M_ARREGION), .M_ARUSER(M_ARUSER),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to 1ns after the next falling edge; inputs change here.
    task automatic nxt();
        @(negedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0;
        cmd_size = 0; cmd_burst = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
        M_AWREADY = 0; M_WREADY = 0; M_BID = 0; M_BRESP = 0; M_BVALID = 0;
        M_ARREADY = 0; M_RID = 0; M_RDATA = 0; M_RRESP = 0; M_RLAST = 0; M_RVALID = 0;
    endtask

    task automatic issue_cmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        int g = 0;
        cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_size = size; cmd_burst = burst;
        #1;
        while (!cmd_ready && g < 100) begin nxt(); g++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1;
        nxt();
        cmd_valid = 0;
        #1;
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("awvalid_t1", M_AWVALID, wr);
        chk("arvalid_t1", M_ARVALID, !wr);
        chk("timeout_cleared", timeout, 0);
    endtask

    task automatic wr_txn(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int aw_delay, input bit gaps, input logic [1:0] bresp,
                          input bit bid_bad);
        logic [31:0] dq [16];
        logic [3:0]  sq [16];
        int b = 0;
        int g = 0;
        for (int i = 0; i < 16; i++) begin dq[i] = $urandom; sq[i] = 4'($urandom); end
        issue_cmd(1, id, addr, len, 3'd2, 2'd1);
        M_AWREADY = 0; wd_valid = 1; wd_data = dq[0]; M_WREADY = 1;
        for (int k = 0; k < aw_delay; k++) begin
            if (k > 0) nxt();
            #1;
            chk("aw_hold_valid", M_AWVALID, 1);
            chk("no_w_before_aw", M_WVALID, 0);
            chk("timeout_flag", timeout, (k >= 256));
        end
        if (aw_delay > 0) nxt();
        M_AWREADY = 1;
        #1;
        chk("aw_valid", M_AWVALID, 1);
        chk("aw_addr", M_AWADDR, addr);
        chk("aw_id", M_AWID, id);
        chk("aw_len", M_AWLEN, {4'b0, len});
        chk("aw_burst", M_AWBURST, 2'd1);
        nxt();
        M_AWREADY = 0;
        while (b <= int'(len) && g < 500) begin
            wd_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            M_WREADY = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wd_data  = dq[b];
            wd_strb  = sq[b];
            #1;
            if (wd_valid && M_WREADY) begin
                chk("w_valid", M_WVALID, 1);
                chk("w_data", M_WDATA, dq[b]);
                chk("w_strb", M_WSTRB, sq[b]);
                chk("w_last", M_WLAST, (b == int'(len)));
                chk("wd_ready", wd_ready, 1);
                b++;
            end
            nxt();
            g++;
        end
        if (g >= 500) chk("w_beats_bound", M_WVALID, 1);
        wd_valid = 0; M_WREADY = 0;
        M_BVALID = 1; M_BID = bid_bad ? (id ^ 4'h1) : id; M_BRESP = bresp;
        #1;
        g = 0;
        while (!M_BREADY && g < 100) begin nxt(); g++; end
        chk("b_ready", M_BREADY, 1);
        nxt();
        M_BVALID = 0;
        #1;
        chk("wr_done_valid", done_valid, 1);
        chk("wr_done_resp", done_resp, bresp);
        chk("wr_done_err", done_err, bid_bad);
        chk("wr_cmd_ready_at_done", cmd_ready, 1);
        nxt();
        chk("wr_done_pulse", done_valid, 0);
        $display("[TB] write id=%0h addr=%08h len=%0d aw_delay=%0d bresp=%0d bid_bad=%0d -> resp=%0d err=%0d",
                 id, addr, len, aw_delay, bresp, bid_bad, done_resp, done_err);
    endtask

    task automatic rd_txn(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] rr [16], input int rlast_at, input int bad_beat,
                          input bit gaps);
        logic [31:0] dq [16];
        logic [1:0]  exp_resp = 2'd0;
        logic        exp_err = 1'b0;
        bit rv = 0;
        bit fin = 0;
        int b = 0;
        int g = 0;
        int ar_delay = gaps ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < 16; i++) dq[i] = $urandom;
        issue_cmd(0, id, addr, len, 3'd2, 2'd1);
        M_ARREADY = 0;
        for (int k = 0; k < ar_delay; k++) begin
            if (k > 0) nxt();
            #1;
            chk("ar_hold_valid", M_ARVALID, 1);
        end
        if (ar_delay > 0) nxt();
        M_ARREADY = 1;
        #1;
        chk("ar_valid", M_ARVALID, 1);
        chk("ar_addr", M_ARADDR, addr);
        chk("ar_id", M_ARID, id);
        chk("ar_len", M_ARLEN, {4'b0, len});
        nxt();
        M_ARREADY = 0;
        while (!fin && g < 500) begin
            if (!rv) rv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            M_RVALID = rv;
            M_RDATA  = dq[b];
            M_RRESP  = rr[b];
            M_RLAST  = (b == rlast_at);
            M_RID    = (b == bad_beat) ? (id ^ 4'h1) : id;
            rd_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk("rd_valid", rd_valid, rv);
            if (rv && rd_ready) begin
                chk("r_ready", M_RREADY, 1);
                chk("rd_data", rd_data, dq[b]);
                chk("rd_last", rd_last, (b == rlast_at));
                if (rr[b] > exp_resp) exp_resp = rr[b];
                if (b == bad_beat) exp_err = 1'b1;
                if ((b == rlast_at) != (b == int'(len))) exp_err = 1'b1;
                if (b == rlast_at) fin = 1;
                b++;
                rv = 0;
            end
            nxt();
            g++;
        end
        if (g >= 500) chk("r_beats_bound", done_valid, 1);
        M_RVALID = 0; M_RLAST = 0; rd_ready = 0;
        #1;
        chk("rd_done_valid", done_valid, 1);
        chk("rd_done_resp", done_resp, exp_resp);
        chk("rd_done_err", done_err, exp_err);
        chk("rd_cmd_ready_at_done", cmd_ready, 1);
        nxt();
        chk("rd_done_pulse", done_valid, 0);
        $display("[TB] read  id=%0h addr=%08h len=%0d rlast_at=%0d bad_beat=%0d beats=%0d -> resp=%0d err=%0d",
                 id, addr, len, rlast_at, bad_beat, b, exp_resp, exp_err);
    endtask

    initial begin
        logic [1:0] rr [16];
        int ln, rl, bb;

        ARESETn = 0;
        idle_inputs();
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", M_AWVALID, 0);
        chk("rst_arvalid", M_ARVALID, 0);
        chk("rst_wvalid", M_WVALID, 0);
        chk("rst_bready", M_BREADY, 0);
        chk("rst_rready", M_RREADY, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_timeout", timeout, 0);
        repeat (3) nxt();
        ARESETn = 1;
        #1;
        chk("cmd_ready_before_edge", cmd_ready, 0);
        nxt();
        chk("cmd_ready_after_edge", cmd_ready, 1);

        // T1: 4-beat INCR write, slave always ready.
        wr_txn(4'h2, 32'h0000_1000, 4'd3, 0, 0, 2'd0, 0);

        // T2: single-beat read returning SLVERR.
        for (int i = 0; i < 16; i++) rr[i] = 2'd0;
        rr[0] = 2'd2;
        rd_txn(4'h5, 32'h0000_2000, 4'd0, rr, 0, -1, 0);

        // T3: 8-beat read, response merge picks DECERR.
        for (int i = 0; i < 16; i++) rr[i] = 2'd0;
        rr[2] = 2'd3; rr[4] = 2'd2;
        rd_txn(4'h7, 32'h0000_3000, 4'd7, rr, 7, -1, 0);

        // T4: early RLAST on beat 1 of a 4-beat read.
        for (int i = 0; i < 16; i++) rr[i] = 2'd1;
        rd_txn(4'h9, 32'h0000_4000, 4'd3, rr, 1, -1, 0);

        // T5: AW stalled 300 cycles; watchdog fires but engine keeps waiting.
        wr_txn(4'hA, 32'h0000_5000, 4'd1, 300, 0, 2'd0, 0);
        chk("timeout_sticky", timeout, 1);

        // T6: reset in the middle of the third write beat.
        issue_cmd(1, 4'h3, 32'h0000_6000, 4'd3, 3'd2, 2'd1);
        M_AWREADY = 1;
        nxt();
        M_AWREADY = 0;
        for (int i = 0; i < 2; i++) begin
            wd_valid = 1; M_WREADY = 1; wd_data = $urandom;
            nxt();
        end
        wd_valid = 1; M_WREADY = 1;
        #1;
        chk("t6_wvalid_pre_reset", M_WVALID, 1);
        ARESETn = 0;
        #1;
        chk("t6_wvalid_async", M_WVALID, 0);
        chk("t6_wd_ready_async", wd_ready, 0);
        chk("t6_awvalid_async", M_AWVALID, 0);
        chk("t6_bready_async", M_BREADY, 0);
        chk("t6_cmd_ready_async", cmd_ready, 0);
        idle_inputs();
        repeat (2) nxt();
        ARESETn = 1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("t6_no_done", done_valid, 0);
        end
        $display("[TB] reset  mid-write abort done");
        wr_txn(4'h3, 32'h0000_6000, 4'd2, 1, 0, 2'd1, 0);

        // Randomized mix of reads and writes with stalls and faults.
        for (int t = 0; t < 14; t++) begin
            ln = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                wr_txn(4'($urandom), $urandom & 32'hFFFF_FFF0, 4'(ln), $urandom_range(0, 5), 1,
                       2'($urandom), ($urandom_range(0, 5) == 0));
            end else begin
                for (int i = 0; i < 16; i++) rr[i] = 2'($urandom_range(0, 7) == 0 ? $urandom : 0);
                rl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, ln) : ln;
                bb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, ln) : -1;
                rd_txn(4'($urandom), $urandom & 32'hFFFF_FFF0, 4'(ln), rr, rl, bb, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
